alu_bit_slice: RTL and testbench

- Single-bit ALU slice for the datapath ALU; N copies are chained through cin/cout to form the word-wide ALU.
- Computes pass-B, add, subtract, AND, OR or XOR of one bit pair.
- Built structurally from gate primitives, fulladder, mux_2to1 and mux_8to1.
- Result and carry are captured in output registers clocked by clk, with asynchronous active-low reset.

---
 rtl/alu_pkg.sv | 14 +
 rtl/alu_bit_slice_if.sv | 14 +
 rtl/alu_bit_core.sv | 44 ++++
 rtl/fulladder.sv | 20 ++
 rtl/mux_2to1.sv | 10 +
 rtl/mux_8to1.sv | 22 ++
 rtl/alu_bit_slice.sv | 34 +++
 tb/tb_alu_bit_slice.sv | 163 ++++++++++++++++
 8 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the bit-sliced datapath ALU: operation codes and gate delay.
package alu_pkg;

    localparam logic [2:0] OP_PASS_B = 3'b000;
    localparam logic [2:0] OP_ADD    = 3'b010;
    localparam logic [2:0] OP_SUB    = 3'b011;
    localparam logic [2:0] OP_AND    = 3'b100;
    localparam logic [2:0] OP_OR     = 3'b101;
    localparam logic [2:0] OP_XOR    = 3'b110;

    // Nominal gate delay in ns; timing only, no effect on the logic.
    localparam real DELAY = 0.05;

endpackage

// File: rtl/alu_bit_slice_if.sv
// Operand/opcode bundle for one ALU bit slice and its registered outputs.
interface alu_bit_slice_if;

    logic       a;
    logic       b;
    logic       cin;
    logic [2:0] op;
    logic       result;
    logic       cout;

    modport master (output a, b, cin, op, input result, cout);
    modport slave  (input a, b, cin, op, output result, cout);

endinterface

// File: rtl/alu_bit_core.sv
// Combinational part of one ALU bit: operand inversion, full adder, logic gates, result mux.
module alu_bit_core
    import alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic [2:0] op,
    output logic       result,
    output logic       cout
);

    logic b_n;
    logic b_sel;
    logic sum;
    logic and_ab;
    logic or_ab;
    logic xor_ab;

    not g_bn (b_n, b);

    // op[0] inverts B so that op 011 subtracts via the chained carry.
    mux_2to1 u_bsel (.inputs({b_n, b}), .sel(op[0]), .out(b_sel));

    fulladder u_fa (
        .a         (a),
        .b         (b_sel),
        .carry_in  (cin),
        .sum       (sum),
        .carry_out (cout)
    );

    and g_and (and_ab, a, b);
    or  g_or  (or_ab,  a, b);
    xor g_xor (xor_ab, a, b);

    // Slot order matches the opcode: 0 pass-B, 2/3 adder, 4 AND, 5 OR, 6 XOR, 1/7 reserved.
    mux_8to1 u_sel (
        .inputs  ({1'b0, xor_ab, or_ab, and_ab, sum, sum, 1'b0, b}),
        .selects (op),
        .out     (result)
    );

endmodule

// File: rtl/fulladder.sv
// Gate-level one-bit full adder.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic sum,
    output logic carry_out
);

    logic prop;
    logic gen;
    logic prop_carry;

    xor g_prop (prop, a, b);
    xor g_sum  (sum, prop, carry_in);
    and g_gen  (gen, a, b);
    and g_pc   (prop_carry, carry_in, prop);
    or  g_cout (carry_out, gen, prop_carry);

endmodule

// File: rtl/mux_2to1.sv
// Two-input multiplexer; sel picks inputs[1] when high.
module mux_2to1 (
    input  logic [1:0] inputs,
    input  logic       sel,
    output logic       out
);

    assign out = sel ? inputs[1] : inputs[0];

endmodule

// File: rtl/mux_8to1.sv
// Eight-input multiplexer built as a three-level tree of 2:1 muxes.
module mux_8to1 (
    input  logic [7:0] inputs,
    input  logic [2:0] selects,
    output logic       out
);

    logic [3:0] level0;
    logic [1:0] level1;

    // Each level consumes one select bit, LSB first.
    mux_2to1 u_l0_0 (.inputs(inputs[1:0]), .sel(selects[0]), .out(level0[0]));
    mux_2to1 u_l0_1 (.inputs(inputs[3:2]), .sel(selects[0]), .out(level0[1]));
    mux_2to1 u_l0_2 (.inputs(inputs[5:4]), .sel(selects[0]), .out(level0[2]));
    mux_2to1 u_l0_3 (.inputs(inputs[7:6]), .sel(selects[0]), .out(level0[3]));

    mux_2to1 u_l1_0 (.inputs(level0[1:0]), .sel(selects[1]), .out(level1[0]));
    mux_2to1 u_l1_1 (.inputs(level0[3:2]), .sel(selects[1]), .out(level1[1]));

    mux_2to1 u_l2   (.inputs(level1),      .sel(selects[2]), .out(out));

endmodule

// File: rtl/alu_bit_slice.sv
// One registered ALU bit slice: combinational core followed by result/carry flops.
module alu_bit_slice
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    alu_bit_slice_if.slave    bus
);

    logic result_d;
    logic cout_d;

    alu_bit_core u_core (
        .a      (bus.a),
        .b      (bus.b),
        .cin    (bus.cin),
        .op     (bus.op),
        .result (result_d),
        .cout   (cout_d)
    );

    // NOTE: non-blocking assignments keep every flop sampling pre-edge values; the
    // asynchronous reset sits in the sensitivity list so it acts without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.result <= 1'b0;
            bus.cout   <= 1'b0;
        end else begin
            bus.result <= result_d;
            bus.cout   <= cout_d;
        end
    end

endmodule

// File: tb/tb_alu_bit_slice.sv
// Directed and exhaustive checks of the registered ALU bit slice.
module tb_alu_bit_slice;
    import alu_pkg::*;

    typedef struct {
        logic [2:0] op;
        logic       a;
        logic       b;
        logic       cin;
        logic       exp_result;
        logic       exp_cout;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    alu_bit_slice_if bus ();

    alu_bit_slice dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic actual, input logic expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, actual, expected);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic a, input logic b, input logic cin);
        bus.op  = op;
        bus.a   = a;
        bus.b   = b;
        bus.cin = cin;
    endtask

    // Inputs change on the falling edge, outputs are sampled 1 ns after the rising edge.
    task automatic apply_and_clock(input logic [2:0] op, input logic a, input logic b, input logic cin);
        @(negedge clk);
        drive(op, a, b, cin);
        @(posedge clk);
        #1;
    endtask

    // Reference: integer add of a, (optionally inverted) b and cin; returns {cout, result}.
    function automatic logic [1:0] model(input logic [2:0] op, input logic a, input logic b,
                                         input logic cin);
        logic [1:0] total;
        logic       res;
        logic       bo;
        bo    = op[0] ? ~b : b;
        total = {1'b0, a} + {1'b0, bo} + {1'b0, cin};
        case (op)
            3'b000:  res = b;
            3'b010:  res = total[0];
            3'b011:  res = total[0];
            3'b100:  res = a & b;
            3'b101:  res = a | b;
            3'b110:  res = a ^ b;
            default: res = 1'b0;
        endcase
        return {total[1], res};
    endfunction

    vec_t vecs [16];

    initial begin
        n_checks = 0;
        n_fail   = 0;

        vecs[0]  = '{OP_PASS_B, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{OP_PASS_B, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[2]  = '{OP_ADD,    1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{OP_ADD,    1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{OP_SUB,    1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{OP_SUB,    1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{OP_SUB,    1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{OP_AND,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{OP_AND,    1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[9]  = '{OP_OR,     1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[10] = '{OP_OR,     1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{OP_XOR,    1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{OP_XOR,    1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{3'b001,    1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{3'b111,    1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[15] = '{3'b111,    1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

        // Reset held with inputs that would otherwise produce 1.
        rst_n = 1'b0;
        drive(OP_AND, 1'b1, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_result", bus.result, 1'b0);
        check("reset_cout",   bus.cout,   1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_no_edge_result", bus.result, 1'b0);
        @(posedge clk);
        #1;
        check("first_load_result", bus.result, 1'b1);
        check("first_load_cout",   bus.cout,   1'b1);

        for (int i = 0; i < 16; i++) begin
            apply_and_clock(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin);
            check($sformatf("vec%0d_op%b_result", i, vecs[i].op), bus.result, vecs[i].exp_result);
            check($sformatf("vec%0d_op%b_cout", i, vecs[i].op), bus.cout, vecs[i].exp_cout);
        end

        // One-cycle latency: new inputs must not show before the next rising edge.
        apply_and_clock(OP_PASS_B, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        drive(OP_PASS_B, 1'b0, 1'b0, 1'b0);
        #1;
        check("latency_hold_result", bus.result, 1'b1);
        @(posedge clk);
        #1;
        check("latency_update_result", bus.result, 1'b0);

        for (int k = 0; k < 64; k++) begin
            logic [5:0] v;
            logic [1:0] exp;
            v   = k[5:0];
            exp = model(v[5:3], v[2], v[1], v[0]);
            apply_and_clock(v[5:3], v[2], v[1], v[0]);
            check($sformatf("sweep_op%b_a%b_b%b_c%b_result", v[5:3], v[2], v[1], v[0]),
                  bus.result, exp[0]);
            check($sformatf("sweep_op%b_a%b_b%b_c%b_cout", v[5:3], v[2], v[1], v[0]),
                  bus.cout, exp[1]);
        end

        // Asynchronous reset between edges clears outputs at once and drops the pending value.
        apply_and_clock(OP_ADD, 1'b1, 1'b1, 1'b1);
        check("pre_pulse_result", bus.result, 1'b1);
        check("pre_pulse_cout",   bus.cout,   1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_pulse_result", bus.result, 1'b0);
        check("async_pulse_cout",   bus.cout,   1'b0);
        #1;
        rst_n = 1'b1;
        #1;
        check("after_pulse_hold_result", bus.result, 1'b0);
        check("after_pulse_hold_cout",   bus.cout,   1'b0);
        @(posedge clk);
        #1;
        check("after_pulse_reload_result", bus.result, 1'b1);
        check("after_pulse_reload_cout",   bus.cout,   1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
